shared_memory_arbiter: RTL and testbench



---
 rtl/shared_memory_arbiter.sv | 126 ++++++++++++
 tb/tb_shared_memory_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_memory_arbiter.sv
// Shares one single-port memory between instruction and data requesters, one transaction at a time.
// Define ARBITER_ROUND_ROBIN_EN for alternating priority on contention; otherwise data always wins.
module shared_memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_mem_read,
  input  logic [ADDRESS_BITS-1:0]   i_mem_address_in,
  output logic                      i_mem_ready,
  output logic                      i_mem_valid,
  output logic [DATA_WIDTH-1:0]     i_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   i_mem_address_out,
  input  logic                      d_mem_read,
  input  logic                      d_mem_write,
  input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
  output logic                      d_mem_ready,
  output logic                      d_mem_valid,
  output logic [DATA_WIDTH-1:0]     d_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   mem_address_out,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  input  logic                      mem_ready,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [ADDRESS_BITS-1:0]   mem_address_in
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t state;
  logic   last_grant;
  logic   i_req;
  logic   d_req;
  logic   pick_d;
  logic   grant_i;
  logic   grant_d;

  // last_grant: 0 = instruction channel, 1 = data channel
  always_comb begin
    i_req = i_mem_read;
    d_req = d_mem_read | d_mem_write;
`ifdef ARBITER_ROUND_ROBIN_EN
    pick_d = d_req && (!i_req || !last_grant);
`else
    pick_d = d_req;
`endif
    grant_d = (state == IDLE) && mem_ready && pick_d;
    grant_i = (state == IDLE) && mem_ready && i_req && !pick_d;
  end

  // With no request pending both readies follow mem_ready; otherwise only the winner sees it
  always_comb begin
    i_mem_ready = (state == IDLE) && mem_ready && !pick_d;
    d_mem_ready = (state == IDLE) && mem_ready && (pick_d || !i_req);
  end

  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_en     = '0;
    mem_address_out = '0;
    mem_data_out    = '0;
    if (grant_d) begin
      mem_read        = d_mem_read && !d_mem_write;
      mem_write       = d_mem_write;
      mem_byte_en     = d_mem_byte_en;
      mem_address_out = d_mem_address_in;
      mem_data_out    = d_mem_data_in;
    end else if (grant_i) begin
      mem_read        = 1'b1;
      mem_address_out = i_mem_address_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      last_grant        <= 1'b0;
      i_mem_valid       <= 1'b0;
      i_mem_data_out    <= '0;
      i_mem_address_out <= '0;
      d_mem_valid       <= 1'b0;
      d_mem_data_out    <= '0;
      d_mem_address_out <= '0;
    end else begin
      i_mem_valid <= 1'b0;
      d_mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= D_BUSY;
            last_grant <= 1'b1;
          end else if (grant_i) begin
            state      <= I_BUSY;
            last_grant <= 1'b0;
          end
        end
        I_BUSY: begin
          if (mem_valid) begin
            i_mem_data_out    <= mem_data_in;
            i_mem_address_out <= mem_address_in;
            i_mem_valid       <= 1'b1;
            state             <= IDLE;
          end
        end
        D_BUSY: begin
          if (mem_valid) begin
            d_mem_data_out    <= mem_data_in;
            d_mem_address_out <= mem_address_in;
            d_mem_valid       <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Directed bench for shared_memory_arbiter: scoreboarded responses, immediate-assertion checks.
// Honours ARBITER_ROUND_ROBIN_EN to pick the expected contention order.
module tb_shared_memory_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address_in;
  logic          i_mem_ready;
  logic          i_mem_valid;
  logic [DW-1:0] i_mem_data_out;
  logic [AW-1:0] i_mem_address_out;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [BW-1:0] d_mem_byte_en;
  logic [AW-1:0] d_mem_address_in;
  logic [DW-1:0] d_mem_data_in;
  logic          d_mem_ready;
  logic          d_mem_valid;
  logic [DW-1:0] d_mem_data_out;
  logic [AW-1:0] d_mem_address_out;
  logic          mem_read;
  logic          mem_write;
  logic [BW-1:0] mem_byte_en;
  logic [AW-1:0] mem_address_out;
  logic [DW-1:0] mem_data_out;
  logic          mem_ready;
  logic          mem_valid;
  logic [DW-1:0] mem_data_in;
  logic [AW-1:0] mem_address_in;

  shared_memory_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock(clock), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in),
    .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid),
    .i_mem_data_out(i_mem_data_out), .i_mem_address_out(i_mem_address_out),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
    .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
    .d_mem_ready(d_mem_ready), .d_mem_valid(d_mem_valid),
    .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
    .mem_address_out(mem_address_out), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_data_in(mem_data_in), .mem_address_in(mem_address_in)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } resp_t;

  resp_t         sb[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] model_i_data;
  logic [AW-1:0] model_i_addr;
  logic [DW-1:0] model_d_data;
  logic [AW-1:0] model_d_addr;
  bit            model_last_d;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_mem_read       = 1'b0;
    i_mem_address_in = '0;
    d_mem_read       = 1'b0;
    d_mem_write      = 1'b0;
    d_mem_byte_en    = '0;
    d_mem_address_in = '0;
    d_mem_data_in    = '0;
  endtask

  task automatic apply_stimulus(input bit i_rd, input logic [AW-1:0] i_addr,
                                input bit d_rd, input bit d_wr, input logic [AW-1:0] d_addr,
                                input logic [DW-1:0] d_data, input logic [BW-1:0] d_be);
    i_mem_read       = i_rd;
    i_mem_address_in = i_addr;
    d_mem_read       = d_rd;
    d_mem_write      = d_wr;
    d_mem_address_in = d_addr;
    d_mem_data_in    = d_data;
    d_mem_byte_en    = d_be;
  endtask

  task automatic model_reset();
    sb.delete();
    model_i_data = '0;
    model_i_addr = '0;
    model_d_data = '0;
    model_d_addr = '0;
    model_last_d = 1'b0;
  endtask

  task automatic check_quiet_state(input string tag);
    check_output({tag, "_i_valid"}, 64'(i_mem_valid), 64'(0));
    check_output({tag, "_d_valid"}, 64'(d_mem_valid), 64'(0));
    check_output({tag, "_i_data"}, 64'(i_mem_data_out), 64'(model_i_data));
    check_output({tag, "_i_addr"}, 64'(i_mem_address_out), 64'(model_i_addr));
    check_output({tag, "_d_data"}, 64'(d_mem_data_out), 64'(model_d_data));
    check_output({tag, "_d_addr"}, 64'(d_mem_address_out), 64'(model_d_addr));
  endtask

  task automatic check_mem_idle(input string tag);
    check_output({tag, "_mem_read"}, 64'(mem_read), 64'(0));
    check_output({tag, "_mem_write"}, 64'(mem_write), 64'(0));
    check_output({tag, "_mem_addr"}, 64'(mem_address_out), 64'(0));
    check_output({tag, "_mem_data"}, 64'(mem_data_out), 64'(0));
    check_output({tag, "_mem_be"}, 64'(mem_byte_en), 64'(0));
  endtask

  task automatic expect_grant(input bit is_d, input bit is_wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [BW-1:0] be);
    #1;
    check_output("grant_i_ready", 64'(i_mem_ready), 64'(!is_d));
    check_output("grant_d_ready", 64'(d_mem_ready), 64'(is_d));
    check_output("grant_mem_read", 64'(mem_read), 64'(!is_wr));
    check_output("grant_mem_write", 64'(mem_write), 64'(is_wr));
    check_output("grant_mem_addr", 64'(mem_address_out), 64'(addr));
    check_output("grant_mem_data", 64'(mem_data_out), 64'(data));
    check_output("grant_mem_be", 64'(mem_byte_en), 64'(be));
    model_last_d = is_d;
  endtask

  task automatic check_response();
    resp_t r;
    check_output("sb_depth", 64'(sb.size()), 64'(1));
    if (sb.size() != 0) begin
      r = sb.pop_front();
      if (r.is_d) begin
        model_d_data = r.data;
        model_d_addr = r.addr;
      end else begin
        model_i_data = r.data;
        model_i_addr = r.addr;
      end
      check_output("resp_i_valid", 64'(i_mem_valid), 64'(!r.is_d));
      check_output("resp_d_valid", 64'(d_mem_valid), 64'(r.is_d));
      check_output("resp_i_data", 64'(i_mem_data_out), 64'(model_i_data));
      check_output("resp_i_addr", 64'(i_mem_address_out), 64'(model_i_addr));
      check_output("resp_d_data", 64'(d_mem_data_out), 64'(model_d_data));
      check_output("resp_d_addr", 64'(d_mem_address_out), 64'(model_d_addr));
    end
  endtask

  // Called one cycle or more after a grant, while the arbiter should be busy
  task automatic mem_respond(input bit is_d, input logic [DW-1:0] data, input logic [AW-1:0] addr);
    resp_t r;
    #1;
    check_output("busy_i_ready", 64'(i_mem_ready), 64'(0));
    check_output("busy_d_ready", 64'(d_mem_ready), 64'(0));
    check_output("busy_i_valid", 64'(i_mem_valid), 64'(0));
    check_output("busy_d_valid", 64'(d_mem_valid), 64'(0));
    r.is_d = is_d;
    r.data = data;
    r.addr = addr;
    sb.push_back(r);
    mem_valid      = 1'b1;
    mem_data_in    = data;
    mem_address_in = addr;
    @(negedge clock);
    mem_valid      = 1'b0;
    mem_data_in    = '0;
    mem_address_in = '0;
    #1;
    check_response();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit            exp_d;
    logic [AW-1:0] exp_addr;

    clear_inputs();
    mem_ready      = 1'b1;
    mem_valid      = 1'b0;
    mem_data_in    = '0;
    mem_address_in = '0;
    model_reset();
    reset = 1'b1;
    @(negedge clock);
    #1;
    check_quiet_state("reset");
    check_mem_idle("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single instruction read with two-cycle memory latency
    apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
    expect_grant(1'b0, 1'b0, 32'h100, '0, '0);
    @(negedge clock);
    clear_inputs();
    #1;
    check_mem_idle("i_busy");
    @(negedge clock);
    mem_respond(1'b0, 32'hDEADBEEF, 32'h100);
    @(negedge clock);
    #1;
    check_quiet_state("i_after");

    // Data write with partial byte enables
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011);
    expect_grant(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
    @(negedge clock);
    clear_inputs();
    mem_respond(1'b1, 32'h0, 32'h200);

    // Read+write together is a write
    @(negedge clock);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 32'h240, 32'h0BADF00D, 4'b1111);
    expect_grant(1'b1, 1'b1, 32'h240, 32'h0BADF00D, 4'b1111);
    @(negedge clock);
    clear_inputs();
    mem_respond(1'b1, 32'h11, 32'h240);

    // Contention from a fresh reset so last_grant starts at instruction
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 32'h300 + k, 1'b1, 1'b0, 32'h400 + k, '0, '0);
`ifdef ARBITER_ROUND_ROBIN_EN
      exp_d = !model_last_d;
`else
      exp_d = 1'b1;
`endif
      exp_addr = exp_d ? 32'h400 + k : 32'h300 + k;
      expect_grant(exp_d, 1'b0, exp_addr, '0, '0);
      @(negedge clock);
      mem_respond(exp_d, 32'hA000 + k, exp_addr);
    end
    clear_inputs();

    // Response with nothing outstanding is ignored
    @(negedge clock);
    mem_valid      = 1'b1;
    mem_data_in    = 32'hBAD0BAD0;
    mem_address_in = 32'hFFF;
    @(negedge clock);
    mem_valid      = 1'b0;
    mem_data_in    = '0;
    mem_address_in = '0;
    #1;
    check_quiet_state("spurious");

    // Memory stall holds the request off until mem_ready returns
    @(negedge clock);
    mem_ready = 1'b0;
    apply_stimulus(1'b1, 32'h600, 1'b0, 1'b0, '0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_output("stall_i_ready", 64'(i_mem_ready), 64'(0));
      check_output("stall_mem_read", 64'(mem_read), 64'(0));
      @(negedge clock);
    end
    mem_ready = 1'b1;
    expect_grant(1'b0, 1'b0, 32'h600, '0, '0);
    @(negedge clock);
    clear_inputs();
    mem_respond(1'b0, 32'h60606060, 32'h600);

    // Data request blocked during I_BUSY, granted in the i_mem_valid cycle
    clear_inputs();
    @(negedge clock);
    apply_stimulus(1'b1, 32'h700, 1'b0, 1'b0, '0, '0, '0);
    expect_grant(1'b0, 1'b0, 32'h700, '0, '0);
    @(negedge clock);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h800, '0, '0);
    #1;
    check_output("block_d_ready0", 64'(d_mem_ready), 64'(0));
    check_output("block_mem_read0", 64'(mem_read), 64'(0));
    @(negedge clock);
    #1;
    check_output("block_d_ready1", 64'(d_mem_ready), 64'(0));
    mem_respond(1'b0, 32'h70707070, 32'h700);
    expect_grant(1'b1, 1'b0, 32'h800, '0, '0);
    @(negedge clock);
    clear_inputs();
    mem_respond(1'b1, 32'h5555AAAA, 32'h800);

    // Reset in the middle of D_BUSY drops the in-flight response
    @(negedge clock);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 32'h900, 32'hCAFEF00D, 4'b1111);
    expect_grant(1'b1, 1'b1, 32'h900, 32'hCAFEF00D, 4'b1111);
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    check_quiet_state("midreset");
    check_mem_idle("midreset");
    check_output("midreset_i_ready", 64'(i_mem_ready), 64'(1));
    check_output("midreset_d_ready", 64'(d_mem_ready), 64'(1));
    @(negedge clock);
    reset          = 1'b0;
    mem_valid      = 1'b1;
    mem_data_in    = 32'h77;
    mem_address_in = 32'h900;
    @(negedge clock);
    mem_valid      = 1'b0;
    mem_data_in    = '0;
    mem_address_in = '0;
    #1;
    check_quiet_state("postreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
